// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

  localparam int TIMER_W = 20;
  localparam logic [7:0] LOSS_MAX = 8'd255;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    RUNNING    = 3'd3,
    FAULT      = 3'd4
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with a synchronous active-high reset to zero.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample the
  // pre-edge values; blocking here would collapse the chain into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the PLL in reset, waits for a debounced lock with bounded retries, then
// releases the system reset; re-sequences on lock loss or an explicit restart.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state
);

  localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]         RETRY_LIMIT  = 4'(MAX_RETRIES);

  logic               lock_s;
  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         retry_d;
  logic [7:0]         loss_d;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    retry_d = retry_cnt;
    loss_d  = lock_loss_cnt;

    if (restart) begin
      state_d = RESET_HOLD;
      retry_d = '0;
    end else begin
      unique case (state_q)
        RESET_HOLD: if (timer_q == RST_LAST) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
          end else if (timer_q == TIMEOUT_LAST) begin
            if (retry_cnt == RETRY_LIMIT) begin
              state_d = FAULT;
            end else begin
              state_d = RESET_HOLD;
              retry_d = retry_cnt + 4'd1;
            end
          end
        end
        STABLE: begin
          // Any dropout falls back to WAIT_LOCK so the debounce starts over.
          if (!lock_s) begin
            state_d = WAIT_LOCK;
          end else if (timer_q == STABLE_LAST) begin
            state_d = RUNNING;
            retry_d = '0;
          end
        end
        RUNNING: begin
          if (!lock_s) begin
            state_d = RESET_HOLD;
            if (lock_loss_cnt != LOSS_MAX) loss_d = lock_loss_cnt + 8'd1;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = RESET_HOLD;
      endcase
    end

    // A restart counts as a transition even when it lands back in RESET_HOLD.
    timer_d = (restart || (state_d != state_q)) ? '0 : timer_q + 1'b1;
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q       <= RESET_HOLD;
      timer_q       <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_cnt     <= retry_d;
      lock_loss_cnt <= loss_d;
      pll_rst       <= (state_d == RESET_HOLD) || (state_d == FAULT);
      sys_rst       <= (state_d != RUNNING);
      ready         <= (state_d == RUNNING);
      fault         <= (state_d == FAULT);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with RST_CYCLES=4, LOCK_TIMEOUT=32,
// STABLE_CYCLES=8, MAX_RETRIES=2; expected values are hand-derived constants.
module tb_pll_reset_sequencer;

  localparam logic [2:0] S_HOLD = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_STAB = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_FLT  = 3'd4;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  pll_reset_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .restart       (restart),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt),
    .state         (state)
  );

  always #10 refclk = ~refclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
    int n = 0;
    while (state !== target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(state), 32'(target));
  endtask

  task automatic go_running();
    pll_locked = 1'b1;
    wait_state("reach_running", S_RUN, 64);
  endtask

  task automatic lose_lock();
    pll_locked = 1'b0;
    ticks(3);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    restart    = 1'b0;
    ticks(3);

    // Reset values
    check("rst_state", 32'(state), 32'(S_HOLD));
    check("rst_pll_rst", 32'(pll_rst), 32'd1);
    check("rst_sys_rst", 32'(sys_rst), 32'd1);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_retry", 32'(retry_cnt), 32'd0);
    check("rst_loss", 32'(lock_loss_cnt), 32'd0);

    // Nominal start: hold lasts exactly 4 cycles
    rst = 1'b0;
    ticks(3);
    check("hold_3_state", 32'(state), 32'(S_HOLD));
    check("hold_3_pll_rst", 32'(pll_rst), 32'd1);
    tick();
    check("hold_4_state", 32'(state), 32'(S_WAIT));
    check("hold_4_pll_rst", 32'(pll_rst), 32'd0);
    check("wait_sys_rst", 32'(sys_rst), 32'd1);

    // Lock arrives: 2 sync cycles, then STABLE on the third edge
    pll_locked = 1'b1;
    ticks(2);
    check("sync_latency_state", 32'(state), 32'(S_WAIT));
    tick();
    check("stable_entry", 32'(state), 32'(S_STAB));
    ticks(7);
    check("debounce_7_ready", 32'(ready), 32'd0);
    check("debounce_7_state", 32'(state), 32'(S_STAB));
    tick();
    check("run_ready", 32'(ready), 32'd1);
    check("run_sys_rst", 32'(sys_rst), 32'd0);
    check("run_state", 32'(state), 32'(S_RUN));
    check("run_retry", 32'(retry_cnt), 32'd0);
    check("run_pll_rst", 32'(pll_rst), 32'd0);

    // Lock loss while running
    pll_locked = 1'b0;
    ticks(2);
    check("loss_pre_ready", 32'(ready), 32'd1);
    tick();
    check("loss_state", 32'(state), 32'(S_HOLD));
    check("loss_sys_rst", 32'(sys_rst), 32'd1);
    check("loss_ready", 32'(ready), 32'd0);
    check("loss_pll_rst", 32'(pll_rst), 32'd1);
    check("loss_cnt_1", 32'(lock_loss_cnt), 32'd1);

    go_running();
    lose_lock();
    go_running();
    lose_lock();
    check("loss_cnt_3", 32'(lock_loss_cnt), 32'd3);

    // Restart coincident with lock loss: no increment
    go_running();
    pll_locked = 1'b0;
    ticks(2);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("rs_loss_state", 32'(state), 32'(S_HOLD));
    check("rs_loss_cnt", 32'(lock_loss_cnt), 32'd3);

    // Restart from RUNNING
    go_running();
    pulse_restart();
    check("rs_run_state", 32'(state), 32'(S_HOLD));
    check("rs_run_ready", 32'(ready), 32'd0);
    check("rs_run_sys_rst", 32'(sys_rst), 32'd1);
    check("rs_run_retry", 32'(retry_cnt), 32'd0);
    check("rs_run_loss", 32'(lock_loss_cnt), 32'd3);

    // rst in STABLE restores every reset value
    wait_state("reach_stable", S_STAB, 32);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_state", 32'(state), 32'(S_HOLD));
    check("mid_rst_loss", 32'(lock_loss_cnt), 32'd0);
    check("mid_rst_pll_rst", 32'(pll_rst), 32'd1);
    check("mid_rst_sys_rst", 32'(sys_rst), 32'd1);
    check("mid_rst_retry", 32'(retry_cnt), 32'd0);

    // Debounce glitch: lock_s low for one cycle at STABLE timer 5
    wait_state("glitch_stable", S_STAB, 32);
    ticks(3);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    check("glitch_still_stable", 32'(state), 32'(S_STAB));
    tick();
    check("glitch_back_wait", 32'(state), 32'(S_WAIT));
    tick();
    check("glitch_restable", 32'(state), 32'(S_STAB));
    ticks(7);
    check("glitch_7_ready", 32'(ready), 32'd0);
    tick();
    check("glitch_8_ready", 32'(ready), 32'd1);

    // Saturation of the lock loss counter
    for (int i = 0; i < 260; i++) begin
      lose_lock();
      if (i < 259) go_running();
    end
    check("loss_saturated", 32'(lock_loss_cnt), 32'd255);

    // Lock never arrives: three windows, then FAULT
    pulse_restart();
    check("nl_restart_state", 32'(state), 32'(S_HOLD));
    check("nl_restart_retry", 32'(retry_cnt), 32'd0);
    ticks(3);
    check("nl_hold_state", 32'(state), 32'(S_HOLD));
    tick();
    check("nl_wait_state", 32'(state), 32'(S_WAIT));
    for (int r = 0; r < 3; r++) begin
      ticks(31);
      check("nl_window_state", 32'(state), 32'(S_WAIT));
      check("nl_window_retry", 32'(retry_cnt), 32'(r));
      tick();
      if (r < 2) begin
        check("nl_retry_state", 32'(state), 32'(S_HOLD));
        check("nl_retry_cnt", 32'(retry_cnt), 32'(r + 1));
        check("nl_retry_pll_rst", 32'(pll_rst), 32'd1);
        ticks(4);
        check("nl_rewait_state", 32'(state), 32'(S_WAIT));
      end else begin
        check("nl_fault_state", 32'(state), 32'(S_FLT));
        check("nl_fault", 32'(fault), 32'd1);
        check("nl_fault_pll_rst", 32'(pll_rst), 32'd1);
        check("nl_fault_sys_rst", 32'(sys_rst), 32'd1);
        check("nl_fault_ready", 32'(ready), 32'd0);
        check("nl_fault_retry", 32'(retry_cnt), 32'd2);
      end
    end
    ticks(100);
    check("fault_sticky_state", 32'(state), 32'(S_FLT));
    check("fault_sticky", 32'(fault), 32'd1);

    // Restart from FAULT
    pulse_restart();
    check("rs_flt_state", 32'(state), 32'(S_HOLD));
    check("rs_flt_fault", 32'(fault), 32'd0);
    check("rs_flt_retry", 32'(retry_cnt), 32'd0);
    check("rs_flt_loss", 32'(lock_loss_cnt), 32'd255);
    check("rs_flt_pll_rst", 32'(pll_rst), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
